// File: rtl/lsu_req_ctrl_if.sv
// Pipeline request/response channel plus data-memory subsystem strobes for lsu_req_ctrl.
// Modport slave is the controller's view; master is the pipeline/memory side.
interface lsu_req_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [9:0]  WordAddress;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Stall;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, DataOut, Stall, rsp_ready,
        output req_ready, MemRead, MemWrite, WordAddress, DataIn, rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, DataOut, Stall, rsp_ready,
        input  req_ready, MemRead, MemWrite, WordAddress, DataIn, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_req_ctrl.sv
// Single-outstanding load/store sequencer: accept -> ISSUE -> WAIT (Stall holds) -> RESP; 3-cycle min, misaligned 1-cycle.
// Holds RESP until rsp_ready; req_ready only in IDLE. Optional WAIT watchdog under LSU_TIMEOUT_EN.
module lsu_req_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic           clk,
    input  logic           rst,
    lsu_req_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_we;
    logic [9:0]  r_waddr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_accept;
    logic        w_misalign;
    logic        w_done_ok;
    logic        w_tmo;

    assign w_misalign = (bus.req_addr[1:0] != 2'b00);

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == WAIT) && bus.Stall) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive stalled WAIT cycle.
    assign w_tmo = (r_state == WAIT) && bus.Stall && (r_tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
    logic w_unused_tmo_cfg;
    assign w_unused_tmo_cfg = (TIMEOUT_CYC > 0);
    assign w_tmo            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_done_ok     = 1'b0;
        bus.req_ready = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_misalign ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                bus.MemRead  = ~r_we;
                bus.MemWrite = r_we;
                w_state_nxt  = WAIT;
            end
            WAIT: begin
                bus.MemRead  = ~r_we;
                bus.MemWrite = r_we;
                if (!bus.Stall) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_tmo) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response payload is written only on entry to RESP, so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_we    <= bus.req_we;
            r_waddr <= bus.req_addr[11:2];
            r_wdata <= bus.req_wdata;
            r_rdata <= '0;
            r_err   <= w_misalign;
        end else if (w_done_ok) begin
            r_rdata <= r_we ? 32'h0 : bus.DataOut;
            r_err   <= 1'b0;
        end else if (w_tmo) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end
    end

    assign bus.WordAddress = r_waddr;
    assign bus.DataIn      = r_wdata;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.rsp_err     = r_err;

endmodule
